// File: rtl/micro_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : micro_sequencer_pkg
// Description : Shared constants for the multicycle MIPS micro-sequencer.
//               Holds the sequencing-command encodings, the opcode and funct
//               values used by the dispatch decoder, and the control-state
//               numbers that decoded instructions dispatch to.
// Revision    : 1.0 - initial release
// ============================================================================
package micro_sequencer_pkg;

    // Sequencing commands from the control ROM. Codes 6 and 7 are reserved
    // and the sequencer treats them as HOLD.
    localparam logic [2:0] c_SEQ_INC      = 3'd0;
    localparam logic [2:0] c_SEQ_DISPATCH = 3'd1;
    localparam logic [2:0] c_SEQ_FETCH    = 3'd2;
    localparam logic [2:0] c_SEQ_JUMP     = 3'd3;
    localparam logic [2:0] c_SEQ_COND     = 3'd4;
    localparam logic [2:0] c_SEQ_WAIT     = 3'd5;

    // Opcodes, ir[31:26]
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_SPEC2 = 6'b011100;
    localparam logic [5:0] c_OP_ADDIU = 6'b001001;
    localparam logic [5:0] c_OP_SLTIU = 6'b001011;
    localparam logic [5:0] c_OP_ANDI  = 6'b001100;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_XORI  = 6'b001110;
    localparam logic [5:0] c_OP_LUI   = 6'b001111;
    localparam logic [5:0] c_OP_SB    = 6'b101000;
    localparam logic [5:0] c_OP_SH    = 6'b101001;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_LB    = 6'b100000;
    localparam logic [5:0] c_OP_LH    = 6'b100001;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_LBU   = 6'b100100;
    localparam logic [5:0] c_OP_LHU   = 6'b100101;

    // Funct codes, ir[5:0]
    localparam logic [5:0] c_FN_ADDU = 6'b100001;
    localparam logic [5:0] c_FN_SUBU = 6'b100011;
    localparam logic [5:0] c_FN_SLTU = 6'b101011;
    localparam logic [5:0] c_FN_AND  = 6'b100100;
    localparam logic [5:0] c_FN_OR   = 6'b100101;
    localparam logic [5:0] c_FN_XOR  = 6'b100110;
    localparam logic [5:0] c_FN_NOR  = 6'b100111;
    localparam logic [5:0] c_FN_CLO  = 6'b100001;
    localparam logic [5:0] c_FN_CLZ  = 6'b100000;

    // Dispatch target control states
    localparam int c_ST_ADDU  = 6;
    localparam int c_ST_STORE = 7;
    localparam int c_ST_BEQ   = 11;
    localparam int c_ST_LOAD  = 13;
    localparam int c_ST_SUBU  = 17;
    localparam int c_ST_ADDIU = 18;
    localparam int c_ST_SLTU  = 19;
    localparam int c_ST_SLTIU = 20;
    localparam int c_ST_CLO   = 21;
    localparam int c_ST_CLZ   = 22;
    localparam int c_ST_AND   = 23;
    localparam int c_ST_ANDI  = 24;
    localparam int c_ST_OR    = 25;
    localparam int c_ST_ORI   = 26;
    localparam int c_ST_XOR   = 27;
    localparam int c_ST_XORI  = 28;
    localparam int c_ST_NOR   = 29;
    localparam int c_ST_LUI   = 30;

endpackage
`default_nettype wire

// File: rtl/micro_sequencer_rom.sv
`default_nettype none
// ============================================================================
// Module      : instr_dispatch_rom
// Description : Combinational instruction decoder. Maps the instruction
//               register onto the control state its execution begins in.
//               Unknown encodings map to ILLEGAL_ST with o_illegal set.
// Ports       : i_ir       [31:0]      instruction register
//               o_target   [STATE_W-1] dispatch control state
//               o_illegal              instruction not decodable
// Revision    : 1.0 - initial release
// ============================================================================
module instr_dispatch_rom
    import micro_sequencer_pkg::*;
#(
    parameter int STATE_W    = 7,
    parameter int ILLEGAL_ST = 2
) (
    input  logic [31:0]        i_ir,
    output logic [STATE_W-1:0] o_target,
    output logic               o_illegal
);

    logic [5:0]         w_op;
    logic [5:0]         w_fn;
    logic [STATE_W-1:0] w_tgt;
    logic               w_ill;
    logic [19:0]        w_unused_ir_bits;

    assign w_op             = i_ir[31:26];
    assign w_fn             = i_ir[5:0];
    assign w_unused_ir_bits = i_ir[25:6];

    always_comb begin
        w_tgt = '0;
        w_ill = 1'b0;
        case (w_op)
            c_OP_RTYPE: begin
                case (w_fn)
                    c_FN_ADDU: w_tgt = STATE_W'(c_ST_ADDU);
                    c_FN_SUBU: w_tgt = STATE_W'(c_ST_SUBU);
                    c_FN_SLTU: w_tgt = STATE_W'(c_ST_SLTU);
                    c_FN_AND:  w_tgt = STATE_W'(c_ST_AND);
                    c_FN_OR:   w_tgt = STATE_W'(c_ST_OR);
                    c_FN_XOR:  w_tgt = STATE_W'(c_ST_XOR);
                    c_FN_NOR:  w_tgt = STATE_W'(c_ST_NOR);
                    default:   w_ill = 1'b1;
                endcase
            end
            c_OP_SPEC2: begin
                case (w_fn)
                    c_FN_CLO: w_tgt = STATE_W'(c_ST_CLO);
                    c_FN_CLZ: w_tgt = STATE_W'(c_ST_CLZ);
                    default:  w_ill = 1'b1;
                endcase
            end
            c_OP_ADDIU: w_tgt = STATE_W'(c_ST_ADDIU);
            c_OP_SLTIU: w_tgt = STATE_W'(c_ST_SLTIU);
            c_OP_ANDI:  w_tgt = STATE_W'(c_ST_ANDI);
            c_OP_ORI:   w_tgt = STATE_W'(c_ST_ORI);
            c_OP_XORI:  w_tgt = STATE_W'(c_ST_XORI);
            c_OP_LUI:   w_tgt = STATE_W'(c_ST_LUI);
            c_OP_SB, c_OP_SH, c_OP_SW:
                        w_tgt = STATE_W'(c_ST_STORE);
            c_OP_BEQ:   w_tgt = STATE_W'(c_ST_BEQ);
            c_OP_LB, c_OP_LH, c_OP_LW, c_OP_LBU, c_OP_LHU:
                        w_tgt = STATE_W'(c_ST_LOAD);
            default:    w_ill = 1'b1;
        endcase
        if (w_ill) begin
            w_tgt = STATE_W'(ILLEGAL_ST);
        end
    end

    assign o_target  = w_tgt;
    assign o_illegal = w_ill;

endmodule
`default_nettype wire

// File: rtl/micro_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : micro_sequencer
// Description : Next-state sequencer for the multicycle MIPS control unit.
//               Holds the control-state register (which addresses the
//               control ROM), a one-cycle decode register fed from the IR,
//               and a memory-wait timeout counter.
// Ports       : clk, rst_n              clock, synchronous active-low reset
//               ir, ir_load             instruction register and its load
//               seq_op                  sequencing command from control ROM
//               jump_tgt, cond          JUMP/COND target and branch condition
//               mem_ready               memory operation complete (WAIT)
//               state                   current control state
//               dec_valid               decode register holds current IR
//               illegal, bus_err        sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
module micro_sequencer
    import micro_sequencer_pkg::*;
#(
    parameter int STATE_W     = 7,
    parameter int FETCH_STATE = 1,
    parameter int ILLEGAL_ST  = 2,
    parameter int BUSERR_ST   = 3,
    parameter int WAIT_MAX    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        ir,
    input  logic               ir_load,
    input  logic [2:0]         seq_op,
    input  logic [STATE_W-1:0] jump_tgt,
    input  logic               cond,
    input  logic               mem_ready,
    output logic [STATE_W-1:0] state,
    output logic               dec_valid,
    output logic               illegal,
    output logic               bus_err
);

    localparam int CNT_W = $clog2(WAIT_MAX);

    logic [STATE_W-1:0] r_state,     w_state_nxt;
    logic [STATE_W-1:0] r_dec_q,     w_dec_q_nxt;
    logic               r_dec_ill,   w_dec_ill_nxt;
    logic               r_dec_valid, w_dec_valid_nxt;
    logic               r_illegal,   w_illegal_nxt;
    logic               r_bus_err,   w_bus_err_nxt;
    logic [CNT_W-1:0]   r_wait_cnt,  w_wait_cnt_nxt;

    logic [STATE_W-1:0] w_rom_tgt;
    logic               w_rom_ill;
    logic [STATE_W-1:0] w_state_inc;

    instr_dispatch_rom #(
        .STATE_W    (STATE_W),
        .ILLEGAL_ST (ILLEGAL_ST)
    ) u_rom (
        .i_ir      (ir),
        .o_target  (w_rom_tgt),
        .o_illegal (w_rom_ill)
    );

    assign w_state_inc = r_state + STATE_W'(1);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= '0;
            r_dec_q     <= '0;
            r_dec_ill   <= 1'b0;
            r_dec_valid <= 1'b0;
            r_illegal   <= 1'b0;
            r_bus_err   <= 1'b0;
            r_wait_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_dec_q     <= w_dec_q_nxt;
            r_dec_ill   <= w_dec_ill_nxt;
            r_dec_valid <= w_dec_valid_nxt;
            r_illegal   <= w_illegal_nxt;
            r_bus_err   <= w_bus_err_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt     = r_state;
        w_dec_q_nxt     = r_dec_q;
        w_dec_ill_nxt   = r_dec_ill;
        w_dec_valid_nxt = r_dec_valid;
        w_illegal_nxt   = r_illegal;
        w_bus_err_nxt   = r_bus_err;
        w_wait_cnt_nxt  = '0;   // any non-WAIT command clears the timeout

        case (seq_op)
            c_SEQ_INC: w_state_nxt = w_state_inc;
            c_SEQ_DISPATCH: begin
                // Without a valid decode the sequencer stalls in place.
                if (r_dec_valid) begin
                    w_state_nxt = r_dec_q;
                    if (r_dec_ill) begin
                        w_illegal_nxt = 1'b1;
                    end
                end
            end
            c_SEQ_FETCH: begin
                w_state_nxt     = STATE_W'(FETCH_STATE);
                w_illegal_nxt   = 1'b0;
                w_bus_err_nxt   = 1'b0;
                w_dec_valid_nxt = 1'b0;
            end
            c_SEQ_JUMP: w_state_nxt = jump_tgt;
            c_SEQ_COND: w_state_nxt = cond ? jump_tgt : w_state_inc;
            c_SEQ_WAIT: begin
                if (mem_ready) begin
                    w_state_nxt = w_state_inc;
                end else if (r_wait_cnt == CNT_W'(WAIT_MAX - 1)) begin
                    w_state_nxt   = STATE_W'(BUSERR_ST);
                    w_bus_err_nxt = 1'b1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
                end
            end
            default: ;  // reserved codes hold
        endcase

        // A same-cycle IR load overrides FETCH's clear of dec_valid.
        if (ir_load) begin
            w_dec_q_nxt     = w_rom_tgt;
            w_dec_ill_nxt   = w_rom_ill;
            w_dec_valid_nxt = 1'b1;
        end
    end

    // Outputs, all straight from registers
    always_comb begin
        state     = r_state;
        dec_valid = r_dec_valid;
        illegal   = r_illegal;
        bus_err   = r_bus_err;
    end

endmodule
`default_nettype wire

// File: tb/tb_micro_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_micro_sequencer
// Description : Directed self-checking bench for micro_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_micro_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ir;
    logic        ir_load;
    logic [2:0]  seq_op;
    logic [6:0]  jump_tgt;
    logic        cond;
    logic        mem_ready;
    logic [6:0]  state;
    logic        dec_valid;
    logic        illegal;
    logic        bus_err;

    int n_tests = 0;
    int n_fail  = 0;

    micro_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ir        (ir),
        .ir_load   (ir_load),
        .seq_op    (seq_op),
        .jump_tgt  (jump_tgt),
        .cond      (cond),
        .mem_ready (mem_ready),
        .state     (state),
        .dec_valid (dec_valid),
        .illegal   (illegal),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] INC = 3'd0, DISP = 3'd1, FETCH = 3'd2,
                           JUMP = 3'd3, COND = 3'd4, WAITC = 3'd5;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic [2:0] exp);
        chk(tag, {29'd0, dec_valid, illegal, bus_err}, {29'd0, exp});
    endtask

    initial begin
        rst_n = 1'b0; ir = 32'd0; ir_load = 1'b0; seq_op = JUMP;
        jump_tgt = 7'd9; cond = 1'b0; mem_ready = 1'b0;

        // 1: reset dominates a JUMP
        step();
        step();
        chk("reset_state", state, 0);
        chk_flags("reset_flags", 3'b000);
        rst_n = 1'b1;
        step();
        chk("jump_after_reset", state, 9);

        // 2: ADDU load with DISPATCH in the same cycle stalls, then dispatches
        ir = 32'h0000_0021; ir_load = 1'b1; seq_op = DISP;
        step();
        chk("disp_stall", state, 9);
        chk_flags("dec_valid_set", 3'b100);
        ir_load = 1'b0;
        step();
        chk("disp_addu", state, 6);
        chk_flags("addu_legal", 3'b100);

        // 3: illegal opcode, then FETCH clears
        ir = 32'hFC00_0000; ir_load = 1'b1; seq_op = INC;
        step();
        chk("inc_6", state, 7);
        ir_load = 1'b0; seq_op = DISP;
        step();
        chk("disp_illegal", state, 2);
        chk_flags("illegal_set", 3'b110);
        seq_op = FETCH;
        step();
        chk("fetch", state, 1);
        chk_flags("fetch_clears", 3'b000);
        seq_op = DISP;
        step();
        chk("disp_no_decode", state, 1);

        // FETCH with same-cycle load keeps dec_valid; LW -> 13
        ir = 32'h8C00_0000; ir_load = 1'b1; seq_op = FETCH;
        step();
        chk("fetch_load", state, 1);
        chk_flags("fetch_load_valid", 3'b100);
        ir_load = 1'b0; seq_op = DISP;
        step();
        chk("disp_lw", state, 13);

        // 4: WAIT holds then advances; 16 unready cycles -> bus error
        seq_op = JUMP; jump_tgt = 7'd50;
        step();
        seq_op = WAITC; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait_hold", state, 50);
        end
        mem_ready = 1'b1;
        step();
        chk("wait_ready", state, 51);
        mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) step();
        chk("wait_15", state, 51);
        chk("no_buserr_15", {31'd0, bus_err}, 0);
        step();
        chk("buserr_state", state, 3);
        chk("buserr_flag", {31'd0, bus_err}, 1);
        seq_op = INC;
        step();
        chk("buserr_sticky", {31'd0, bus_err}, 1);
        chk("inc_after_err", state, 4);
        seq_op = FETCH;
        step();
        chk("fetch_clr_buserr", {31'd0, bus_err}, 0);

        // 5: COND taken / not taken, INC wrap, reserved hold
        seq_op = JUMP; jump_tgt = 7'd11;
        step();
        seq_op = COND; jump_tgt = 7'd40; cond = 1'b1;
        step();
        chk("cond_taken", state, 40);
        seq_op = JUMP; jump_tgt = 7'd11;
        step();
        seq_op = COND; jump_tgt = 7'd40; cond = 1'b0;
        step();
        chk("cond_not_taken", state, 12);
        seq_op = JUMP; jump_tgt = 7'd127;
        step();
        seq_op = INC;
        step();
        chk("inc_wrap", state, 0);
        seq_op = 3'd6; jump_tgt = 7'd5;
        step();
        chk("reserved6", state, 0);
        seq_op = 3'd7;
        step();
        chk("reserved7", state, 0);

        // 6: reset mid-WAIT clears the timeout counter
        seq_op = JUMP; jump_tgt = 7'd20;
        step();
        seq_op = WAITC; mem_ready = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("wait10", state, 20);
        rst_n = 1'b0;
        step();
        chk("mid_wait_reset", state, 0);
        chk_flags("mid_wait_flags", 3'b000);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) step();
        chk("cnt_cleared", state, 0);
        chk("cnt_cleared_err", {31'd0, bus_err}, 0);
        step();
        chk("buserr_again", state, 3);

        // Remaining decodes: SB, LUI, CLZ, SUBU, R-type bad funct
        seq_op = DISP;
        ir = 32'hA000_0000; ir_load = 1'b1;
        step();
        ir_load = 1'b0;
        step();
        chk("disp_sb", state, 7);
        ir = 32'h3C00_0000; ir_load = 1'b1;
        step();
        chk("disp_old_decode", state, 7);
        ir_load = 1'b0;
        step();
        chk("disp_lui", state, 30);
        ir = 32'h7000_0020; ir_load = 1'b1;
        step();
        ir_load = 1'b0;
        step();
        chk("disp_clz", state, 22);
        ir = 32'h0000_0023; ir_load = 1'b1;
        step();
        ir_load = 1'b0;
        step();
        chk("disp_subu", state, 17);
        chk("subu_legal", {31'd0, illegal}, 0);
        ir = 32'h0000_003F; ir_load = 1'b1;
        step();
        ir_load = 1'b0;
        step();
        chk("disp_bad_funct", state, 2);
        chk("bad_funct_illegal", {31'd0, illegal}, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
